// File: rtl/bp_be_wb_arbiter.sv
// bp_be_wb_arbiter
//
// Shares one register-file write port between the in-order pipeline
// writeback and the long-latency writeback path (divider / FPU iterative
// ops). The pipeline always wins. Long results that cannot be written
// immediately are held in a small in-order FIFO. When the FIFO head has
// waited starve_limit_p cycles, a dispatch hold is raised so the pipeline
// drains and the head gets a slot.
//
// Ports
//   clk_i, reset_n_i       clock, asynchronous active-low reset
//   pipe_v_i/addr_i/data_i pipeline writeback (always accepted)
//   long_v_i/addr_i/data_i long-latency writeback; transfer on v & ready
//   long_ready_o           FIFO has room (from registered state only)
//   w_v_o/w_addr_o/w_data_o registered regfile write port
//   stall_o                registered dispatch-hold request
//   empty_o                no buffered long result and no long write in flight
module bp_be_wb_arbiter #(
    parameter int addr_width_p   = 5,
    parameter int data_width_p   = 64,
    parameter int fifo_els_p     = 2,
    parameter int starve_limit_p = 4,
    parameter int drop_x0_p      = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    pipe_v_i,
    input  logic [addr_width_p-1:0] pipe_addr_i,
    input  logic [data_width_p-1:0] pipe_data_i,
    input  logic                    long_v_i,
    output logic                    long_ready_o,
    input  logic [addr_width_p-1:0] long_addr_i,
    input  logic [data_width_p-1:0] long_data_i,
    output logic                    w_v_o,
    output logic [addr_width_p-1:0] w_addr_o,
    output logic [data_width_p-1:0] w_data_o,
    output logic                    stall_o,
    output logic                    empty_o
);

    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int age_w_lp = $clog2(starve_limit_p + 1);

    localparam logic [cnt_w_lp-1:0] fifo_full_lp = cnt_w_lp'(fifo_els_p);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp  = ptr_w_lp'(fifo_els_p - 1);
    localparam logic [age_w_lp-1:0] age_max_lp   = age_w_lp'(starve_limit_p);

    // Pointer advance with wrap at fifo_els_p (depth need not be a power of 2).
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_last_lp) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Saturating age increment.
    function automatic logic [age_w_lp-1:0] age_sat_inc(input logic [age_w_lp-1:0] a);
        return (a >= age_max_lp) ? age_max_lp : a + age_w_lp'(1);
    endfunction

    logic [addr_width_p-1:0] addr_mem [fifo_els_p];
    logic [data_width_p-1:0] data_mem [fifo_els_p];

    logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0] count_r, count_next;
    logic [age_w_lp-1:0] age_r, age_next;
    logic                w_long_r;

    logic                    fifo_nonempty, long_xfer;
    logic                    grant_head, grant_byp, enq, deq;
    logic [addr_width_p-1:0] win_addr_p0;
    logic [data_width_p-1:0] win_data_p0;
    logic                    vld_p0, long_win_p0;

    // ---- stage p0: arbitration on inputs and registered FIFO state ----
    assign fifo_nonempty = (count_r != '0);
    assign long_ready_o  = (count_r < fifo_full_lp);
    assign long_xfer     = long_v_i & long_ready_o;

    assign grant_head = ~pipe_v_i & fifo_nonempty;
    assign grant_byp  = ~pipe_v_i & ~fifo_nonempty & long_xfer;
    assign enq        = long_xfer & ~grant_byp;
    assign deq        = grant_head;

    always_comb begin
        win_addr_p0 = pipe_addr_i;
        win_data_p0 = pipe_data_i;
        if (grant_head) begin
            win_addr_p0 = addr_mem[rd_ptr_r];
            win_data_p0 = data_mem[rd_ptr_r];
        end else if (grant_byp) begin
            win_addr_p0 = long_addr_i;
            win_data_p0 = long_data_i;
        end
    end

    // The winner is consumed even when its x0 write is suppressed.
    assign vld_p0 = (pipe_v_i | grant_head | grant_byp)
                  & ~((drop_x0_p != 0) && (win_addr_p0 == '0));
    assign long_win_p0 = grant_head | grant_byp;

    always_comb begin
        count_next = count_r;
        case ({enq, deq})
            2'b10:   count_next = count_r + cnt_w_lp'(1);
            2'b01:   count_next = count_r - cnt_w_lp'(1);
            default: count_next = count_r;
        endcase
    end

    // Age restarts whenever a new entry becomes head (or nothing is buffered).
    always_comb begin
        age_next = '0;
        if (fifo_nonempty && !deq)
            age_next = age_sat_inc(age_r);
    end

    // FIFO storage carries data only; no reset needed.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_mem[wr_ptr_r] <= long_addr_i;
            data_mem[wr_ptr_r] <= long_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            age_r    <= '0;
            stall_o  <= 1'b0;
        end else begin
            if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r <= count_next;
            age_r   <= age_next;
            stall_o <= (age_next == age_max_lp);
        end
    end

    // ---- stage p1: registered write port ----
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_o    <= 1'b0;
            w_long_r <= 1'b0;
            w_addr_o <= '0;
            w_data_o <= '0;
        end else begin
            w_v_o    <= vld_p0;
            w_long_r <= vld_p0 & long_win_p0;
            w_addr_o <= win_addr_p0;
            w_data_o <= win_data_p0;
        end
    end

    assign empty_o = (count_r == '0) & ~(w_v_o & w_long_r);

endmodule
